// File: rtl/chacha_ram_pkg.sv
// Shared constants and reader FSM encoding for the ChaCha20-Poly1305 RAM read path.
// Contents: default RAM word/address widths, keep-mask byte count, reader state enum.
package chacha_ram_pkg;

  localparam int unsigned D_WIDTH_DEF = 128;
  localparam int unsigned A_WIDTH_DEF = 3;
  localparam int unsigned KEEP_W_DEF  = D_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid FIFO between the RAM read port and the output stream.
// Optional feature macro: RAM_READER_KEEP_EN (adds keep payload).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_push, i_data,     write side: word, last flag (+keep)
//   i_last, i_keep
//   i_pop               read side accept of the head entry
//   o_count             occupancy 0..2
//   o_valid, o_data,    head entry
//   o_last, o_keep
module rd_skid_fifo #(
  parameter int unsigned D_WIDTH = 128
`ifdef RAM_READER_KEEP_EN
  ,
  parameter int unsigned KEEP_W  = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [D_WIDTH-1:0] i_data,
  input  logic               i_last,
`ifdef RAM_READER_KEEP_EN
  input  logic [KEEP_W-1:0]  i_keep,
  output logic [KEEP_W-1:0]  o_keep,
`endif
  input  logic               i_pop,
  output logic [1:0]         o_count,
  output logic               o_valid,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_last
);

  logic [D_WIDTH-1:0] r_data_mem [2];
  logic [1:0]         r_last_mem;
`ifdef RAM_READER_KEEP_EN
  logic [KEEP_W-1:0]  r_keep_mem [2];
`endif
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  // A push into a full FIFO is only allowed when the head leaves the same cycle.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data_mem[i] <= '0;
`ifdef RAM_READER_KEEP_EN
        r_keep_mem[i] <= '0;
`endif
      end
      r_last_mem <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_push) begin
        r_data_mem[r_wr_ptr] <= i_data;
        r_last_mem[r_wr_ptr] <= i_last;
`ifdef RAM_READER_KEEP_EN
        r_keep_mem[r_wr_ptr] <= i_keep;
`endif
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= 2'(r_count + 2'(w_push) - 2'(w_pop));
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data_mem[r_rd_ptr];
  assign o_last  = r_last_mem[r_rd_ptr];
`ifdef RAM_READER_KEEP_EN
  assign o_keep  = r_keep_mem[r_rd_ptr];
`endif

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side controller: streams a run of consecutive RAM words as valid/ready.
// Optional feature macro: RAM_READER_KEEP_EN (adds last_bytes input, m_keep output).
// Ports:
//   clk, rst_n                 clock (also the RAM read clock), async active-low reset
//   start, start_addr, len     run command, sampled only in IDLE
//   busy, done                 run status, done is a one-cycle pulse
//   r_en, r_addr, r_data       RAM read port (data one cycle after r_en)
//   m_valid, m_ready, m_data,  output stream
//   m_last (, m_keep)
module ram_stream_reader
  import chacha_ram_pkg::*;
#(
  parameter int unsigned D_WIDTH = D_WIDTH_DEF,
  parameter int unsigned A_WIDTH = A_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [A_WIDTH-1:0]           start_addr,
  input  logic [A_WIDTH:0]             len,
`ifdef RAM_READER_KEEP_EN
  input  logic [$clog2(D_WIDTH/8):0]   last_bytes,
  output logic [D_WIDTH/8-1:0]         m_keep,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         r_en,
  output logic [A_WIDTH-1:0]           r_addr,
  input  logic [D_WIDTH-1:0]           r_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [D_WIDTH-1:0]           m_data,
  output logic                         m_last
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;
  localparam int unsigned LEN_W = A_WIDTH + 1;
`ifdef RAM_READER_KEEP_EN
  localparam int unsigned KEEP_W = D_WIDTH / 8;
  localparam int unsigned LB_W   = $clog2(KEEP_W) + 1;
`endif

  rd_state_t          r_state;
  logic               r_busy;
  logic               r_done;
  logic [A_WIDTH-1:0] r_rd_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_issued;
  logic               r_pend;
  logic               r_pend_last;
`ifdef RAM_READER_KEEP_EN
  logic [LB_W-1:0]    r_last_bytes;
  logic [KEEP_W-1:0]  w_last_mask;
  logic [KEEP_W-1:0]  w_keep_in;
`endif
  logic [LEN_W-1:0]   w_len_clamp;
  logic [1:0]         w_fifo_count;
  logic               w_pop;
  logic               w_room;
  logic               w_last_issue;
  logic               w_drain_empty;

  assign w_len_clamp = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  assign w_pop       = m_valid && m_ready;

  // Issue only if the word still fits once everything in flight has landed.
  assign w_room       = ({1'b0, w_fifo_count} + {2'b0, r_pend}) < (3'd2 + {2'b0, w_pop});
  assign r_en         = (r_state == ST_RUN) && (r_issued != r_len) && w_room;
  assign w_last_issue = (LEN_W'(r_issued + 1'b1) == r_len);

  // Buffer will be empty after this cycle with nothing left in flight.
  assign w_drain_empty = !r_pend &&
                         ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

  // Reader FSM, address/issue counters and read-pending tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_addr    <= '0;
      r_len        <= '0;
      r_issued     <= '0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
`ifdef RAM_READER_KEEP_EN
      r_last_bytes <= '0;
`endif
    end else begin
      r_pend      <= r_en;
      r_pend_last <= r_en && w_last_issue;
      if (r_en) begin
        r_rd_addr <= A_WIDTH'(r_rd_addr + 1'b1);
        r_issued  <= LEN_W'(r_issued + 1'b1);
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_len_clamp == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_RUN;
              r_busy    <= 1'b1;
              r_rd_addr <= start_addr;
              r_len     <= w_len_clamp;
              r_issued  <= '0;
`ifdef RAM_READER_KEEP_EN
              r_last_bytes <= ((last_bytes == '0) || (last_bytes > LB_W'(KEEP_W))) ?
                              LB_W'(KEEP_W) : last_bytes;
`endif
            end
          end
        end
        ST_RUN: begin
          if (r_en && w_last_issue) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_READER_KEEP_EN
  // Low last_bytes lanes are valid on the final word; full words elsewhere.
  always_comb begin
    w_last_mask = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      w_last_mask[i] = (LB_W'(i) < r_last_bytes);
    end
  end
  assign w_keep_in = r_pend_last ? w_last_mask : '1;
`endif

  // r_data is only sampled on the cycle after a read, never while the bus idles.
  rd_skid_fifo #(
    .D_WIDTH (D_WIDTH)
`ifdef RAM_READER_KEEP_EN
    ,
    .KEEP_W  (KEEP_W)
`endif
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pend),
    .i_data  (r_data),
    .i_last  (r_pend_last),
`ifdef RAM_READER_KEEP_EN
    .i_keep  (w_keep_in),
    .o_keep  (m_keep),
`endif
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_last  (m_last)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign r_addr = r_rd_addr;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a registered-read RAM model.
module tb_ram_stream_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   start_addr;
  logic [3:0]   len;
  logic         busy, done, r_en, m_valid, m_ready, m_last;
  logic [2:0]   r_addr;
  logic [127:0] r_data, m_data;
`ifdef RAM_READER_KEEP_EN
  logic [4:0]   last_bytes;
  logic [15:0]  m_keep;
`endif

  logic [127:0] mem [8];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // RAM: registered read; bus carries junk on cycles with no read.
  always @(posedge clk) begin
    if (r_en) r_data <= mem[r_addr];
    else      r_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  ram_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
`ifdef RAM_READER_KEEP_EN
    .last_bytes (last_bytes),
    .m_keep     (m_keep),
`endif
    .busy       (busy),
    .done       (done),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  // One run: mode 0 = ready high, 1 = ready pattern 1,0,0,1,0,1, 2 = random ready + ignored starts.
  task automatic run_stream(input string name, input int addr, input int len_req,
                            input int mode, input int lb);
    int n, cyc, issued, popped, last_pop, kb, exp_cyc;
    bit got_done, pop;
    bit pattern [6];
    logic pv, pr;
    logic [127:0] pd;
    logic [127:0] exp_q [$];
    logic [15:0] exp_keep;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n = (len_req > 8) ? 8 : len_req;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(addr + i) % 8]);
    kb = (lb == 0) ? 16 : lb;
    issued = 0; popped = 0; last_pop = 0; got_done = 0; pv = 0; pr = 0; pd = '0;
    start = 1'b1; start_addr = 3'(addr); len = 4'(len_req);
`ifdef RAM_READER_KEEP_EN
    last_bytes = 5'(lb);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!got_done && cyc < 200) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pattern[(cyc - 1) % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && $urandom_range(0, 2) == 0) begin
        start = 1'b1; start_addr = 3'($urandom); len = 4'($urandom);
`ifdef RAM_READER_KEEP_EN
        last_bytes = 5'($urandom_range(0, 16));
`endif
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      pop = m_valid && m_ready;
      if (cyc == 1) begin
        n_vec++;
        if (busy !== (n > 0)) begin
          n_err++; $display("FAIL %s busy@t+1: got %b exp %b", name, busy, n > 0);
        end
        n_vec++;
        if (r_en !== (n > 0)) begin
          n_err++; $display("FAIL %s r_en@t+1: got %b exp %b", name, r_en, n > 0);
        end
      end
      if (r_en === 1'b1) begin
        n_vec++;
        if (r_addr !== 3'((addr + issued) % 8) || issued >= n) begin
          n_err++;
          $display("FAIL %s r_addr[%0d]: got %0d exp %0d (issue limit %0d)",
                   name, issued, r_addr, (addr + issued) % 8, n);
        end
        issued++;
      end
      n_vec++;
      if ((issued - popped - int'(pop)) > 2) begin
        n_err++; $display("FAIL %s occupancy: got %0d exp <=2", name, issued - popped - int'(pop));
      end
      if (pv && !pr) begin
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          n_err++; $display("FAIL %s stall_hold: got v=%b %h exp v=1 %h", name, m_valid, m_data, pd);
        end
      end
      if (n == 0) begin
        n_vec++;
        if (m_valid !== 1'b0 || r_en !== 1'b0 || busy !== 1'b0) begin
          n_err++; $display("FAIL %s len0_idle: got v=%b r_en=%b busy=%b exp 0", name, m_valid, r_en, busy);
        end
      end
      if (pop) begin
        n_vec++;
        if (popped >= n || m_data !== exp_q[popped] || m_last !== (popped == n - 1)) begin
          n_err++;
          $display("FAIL %s word[%0d]: got %h last=%b exp %h last=%b", name, popped, m_data,
                   m_last, (popped < n) ? exp_q[popped] : 128'h0, popped == n - 1);
        end
        exp_keep = (popped == n - 1) ? 16'((32'd1 << kb) - 1) : 16'hFFFF;
`ifdef RAM_READER_KEEP_EN
        n_vec++;
        if (m_keep !== exp_keep) begin
          n_err++; $display("FAIL %s keep[%0d]: got %h exp %h", name, popped, m_keep, exp_keep);
        end
`endif
        if (mode == 0) begin
          n_vec++;
          if (cyc != 3 + popped) begin
            n_err++; $display("FAIL %s word_cycle[%0d]: got t+%0d exp t+%0d", name, popped, cyc, 3 + popped);
          end
        end
        popped++;
        last_pop = cyc;
      end
      if (done === 1'b1) begin
        got_done = 1;
        exp_cyc = (n == 0) ? 1 : ((mode == 0) ? n + 3 : last_pop + 1);
        n_vec++;
        if (cyc != exp_cyc || popped != n || issued != n) begin
          n_err++;
          $display("FAIL %s done: got t+%0d words=%0d reads=%0d exp t+%0d words=%0d",
                   name, cyc, popped, issued, exp_cyc, n);
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data;
      if (!got_done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: got no done exp done within 200 cycles", name);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL %s after_done: got done=%b busy=%b v=%b exp 0", name, done, busy, m_valid);
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    n_vec++;
    if ({busy, done, r_en, m_valid, m_last} !== 5'b0 || r_addr !== 3'd0 || m_data !== 128'd0) begin
      n_err++;
      $display("FAIL %s zero: got busy=%b done=%b r_en=%b v=%b last=%b addr=%0d data=%h exp all 0",
               name, busy, done, r_en, m_valid, m_last, r_addr, m_data);
    end
`ifdef RAM_READER_KEEP_EN
    n_vec++;
    if (m_keep !== 16'h0) begin
      n_err++; $display("FAIL %s keep_zero: got %h exp 0000", name, m_keep);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
`ifdef RAM_READER_KEEP_EN
    last_bytes = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; start_addr = 3'd0; len = 4'd8; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL midrun_fill: got v=%b busy=%b exp 1 1", m_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        n_err++; $display("FAIL post_reset_quiet: got done=%b busy=%b v=%b exp 0", done, busy, m_valid);
      end
    end
    @(posedge clk); #1;
    run_stream("post_reset_len1", 3, 1, 0, 16);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 30; r++) begin
      run_stream("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 2,
                 int'($urandom_range(0, 16)));
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = {16{8'(k)}};
    test_reset();
    run_stream("basic", 2, 4, 0, 16);
    run_stream("wrap", 6, 4, 0, 16);
    run_stream("backpressure", 2, 4, 1, 16);
    run_stream("len0", 5, 0, 0, 16);
    run_stream("clamp", 1, 13, 0, 16);
    run_stream("full_bp", 4, 8, 1, 16);
    test_reset_midrun();
`ifdef RAM_READER_KEEP_EN
    run_stream("keep5", 0, 2, 0, 5);
    run_stream("keep0", 3, 3, 1, 0);
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
